// File: rtl/ahb_lite_slave_mem.sv
// AHB-lite single-port memory responder.
// Pipelined address/data phases, programmable wait states, byte/half/word
// lanes (little-endian), two-cycle ERROR response.
// Optional macro AHB_SLAVE_MEM_ERR_EN: when defined, illegal transfers
// (bad size, misaligned, out of range) get an ERROR response; when undefined
// there is no error path, the word index wraps modulo MEM_DEPTH, oversize
// hsize is treated as word and the low address bits are forced to the size
// boundary.
module ahb_lite_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

`ifdef AHB_SLAVE_MEM_ERR_EN
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_WAIT = 2'b01, S_ERR1 = 2'b10, S_ERR2 = 2'b11} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_WAIT = 2'b01} state_t;
`endif

  // Byte-lane enables for a transfer of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offs);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << offs;
      2'b01:   m = offs[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replace the enabled byte lanes of a stored word with write data.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [3:0] m);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = m[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  active_q, active_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            offs_q, offs_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic                  hreadyout_q, hreadyout_d;
  logic [1:0]            hresp_q, hresp_d;

  logic [WA_W-1:0]       word_addr_s;
  logic [1:0]            size_s;
  logic [1:0]            offs_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  legal_s;
  logic                  sample_s;
  logic                  commit_s;
  logic [3:0]            wmask_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  unused_s;

  assign unused_s = ^{hburst, hprot, htrans[0]};

  // Decode the presented address phase into lane size, offset, index and legality.
  always_comb begin
    word_addr_s = haddr[ADDR_WIDTH-1:2];
`ifdef AHB_SLAVE_MEM_ERR_EN
    size_s = hsize[1:0];
    offs_s = haddr[1:0];
    idx_s  = word_addr_s[IDX_W-1:0];
    case (hsize)
      3'b000:  legal_s = 1'b1;
      3'b001:  legal_s = (haddr[0] == 1'b0);
      3'b010:  legal_s = (haddr[1:0] == 2'b00);
      default: legal_s = 1'b0;
    endcase
    legal_s = legal_s && (word_addr_s < WA_W'(MEM_DEPTH));
`else
    size_s = (hsize > 3'b010) ? 2'b10 : hsize[1:0];
    case (size_s)
      2'b00:   offs_s = haddr[1:0];
      2'b01:   offs_s = {haddr[1], 1'b0};
      default: offs_s = 2'b00;
    endcase
    idx_s   = IDX_W'(word_addr_s % WA_W'(MEM_DEPTH));
    legal_s = 1'b1;
`endif
  end

  // Read data for a newly sampled read, forwarding a write that commits on the same edge.
  always_comb begin
    sample_s  = hsel && hready && htrans[1] && hreadyout_q;
    commit_s  = active_q && write_q && (state_q == S_IDLE);
    wmask_s   = lane_mask(size_q, offs_q);
    rd_word_s = mem_q[idx_s];
    if (commit_s && (idx_q == idx_s)) begin
      rd_word_s = merge_lanes(rd_word_s, hwdata, wmask_s);
    end else begin
      rd_word_s = mem_q[idx_s];
    end
  end

  // Next-state: accept a new address phase, or advance the wait/error sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    write_d  = write_q;
    size_d   = size_q;
    offs_d   = offs_q;
    idx_d    = idx_q;
    hrdata_d = hrdata_q;
    if (sample_s) begin
      write_d = hwrite;
      size_d  = size_s;
      offs_d  = offs_s;
      idx_d   = idx_s;
      if (legal_s) begin
        active_d = 1'b1;
        hrdata_d = hwrite ? {DATA_WIDTH{1'b0}} : rd_word_s;
        if (WAIT_STATES > 0) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LD;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end else begin
        active_d = 1'b0;
        hrdata_d = {DATA_WIDTH{1'b0}};
        cnt_d    = 4'd0;
`ifdef AHB_SLAVE_MEM_ERR_EN
        state_d  = S_ERR1;
`else
        state_d  = S_IDLE;
`endif
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          active_d = 1'b0;
          hrdata_d = {DATA_WIDTH{1'b0}};
          cnt_d    = 4'd0;
        end
        S_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d   = cnt_q - 4'd1;
          end
        end
`ifdef AHB_SLAVE_MEM_ERR_EN
        S_ERR1: begin
          state_d  = S_ERR2;
          hrdata_d = {DATA_WIDTH{1'b0}};
        end
        S_ERR2: begin
          state_d  = S_IDLE;
          active_d = 1'b0;
          hrdata_d = {DATA_WIDTH{1'b0}};
        end
`endif
        default: begin
          state_d  = S_IDLE;
          active_d = 1'b0;
          hrdata_d = {DATA_WIDTH{1'b0}};
          cnt_d    = 4'd0;
        end
      endcase
    end
`ifdef AHB_SLAVE_MEM_ERR_EN
    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;
`else
    hreadyout_d = (state_d != S_WAIT);
    hresp_d     = 2'b00;
`endif
  end

  // Control and output registers; reset aborts any transfer in flight.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      active_q    <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      offs_q      <= 2'b00;
      idx_q       <= '0;
      hrdata_q    <= {DATA_WIDTH{1'b0}};
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      write_q     <= write_d;
      size_q      <= size_d;
      offs_q      <= offs_d;
      idx_q       <= idx_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Memory array: commit the selected lanes when a write data phase completes.
  always_ff @(posedge hclk) begin
    if (commit_s) begin
      mem_q[idx_q] <= merge_lanes(mem_q[idx_q], hwdata, wmask_s);
    end
  end

  assign hrdata    = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Directed bench for ahb_lite_slave_mem: one zero-wait instance and one
// three-wait-state instance sharing clock, reset and the address/data bus.
module tb_ahb_lite_slave_mem;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout0, hreadyout1;
  logic [1:0]  hresp0, hresp1;
  logic        hready0, hready1;

  int tests = 0;
  int fails = 0;

  assign hready0 = hreadyout0;
  assign hready1 = hreadyout1;

  always #5 hclk = ~hclk;

  ahb_lite_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready0),
    .hwdata(hwdata), .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0)
  );

  ahb_lite_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready1),
    .hwdata(hwdata), .hrdata(hrdata1), .hreadyout(hreadyout1), .hresp(hresp1)
  );

  // One complete non-pipelined transfer on dut0 (d1=0) or dut1 (d1=1).
  task automatic xfer(input bit d1, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] rsp,
                      output logic [1:0] rsp_low, output int lows);
    int guard;
    hsel0 = !d1; hsel1 = d1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
    @(posedge hclk); #1;
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwdata = wd;
    lows = 0; rsp_low = 2'b00; guard = 0;
    while (((d1 ? hreadyout1 : hreadyout0) == 1'b0) && (guard < 40)) begin
      lows++;
      rsp_low = d1 ? hresp1 : hresp0;
      @(posedge hclk); #1;
      guard++;
    end
    if (guard >= 40) begin
      tests++; fails++;
      $display("FAIL xfer_timeout: addr %h still not ready after %0d cycles", a, guard);
    end
    rd  = d1 ? hrdata1 : hrdata0;
    rsp = d1 ? hresp1 : hresp0;
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    hsel0 = 1'b1; hsel1 = 1'b1; htrans = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tests++; if (hreadyout0 !== 1'b1) begin fails++; $display("FAIL reset_ready0: got %b expected 1", hreadyout0); end
      tests++; if (hresp0 !== 2'b00) begin fails++; $display("FAIL reset_resp0: got %b expected 00", hresp0); end
      tests++; if (hrdata0 !== 32'h0) begin fails++; $display("FAIL reset_rdata0: got %h expected 00000000", hrdata0); end
      tests++; if (hreadyout1 !== 1'b1) begin fails++; $display("FAIL reset_ready1: got %b expected 1", hreadyout1); end
      tests++; if (hresp1 !== 2'b00) begin fails++; $display("FAIL reset_resp1: got %b expected 00", hresp1); end
      tests++; if (hrdata1 !== 32'h0) begin fails++; $display("FAIL reset_rdata1: got %h expected 00000000", hrdata1); end
      @(posedge hclk); #1;
    end
    hsel0 = 1'b0; hsel1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    hsel0 = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    tests++; if (hreadyout0 !== 1'b1) begin fails++; $display("FAIL b2b_wr_ready: got %b expected 1", hreadyout0); end
    hwdata = 32'hDEADBEEF; haddr = 32'h10; hwrite = 1'b0;
    @(posedge hclk); #1;
    hsel0 = 1'b0; htrans = 2'b00; hwdata = 32'h0;
    tests++; if (hreadyout0 !== 1'b1) begin fails++; $display("FAIL b2b_rd_ready: got %b expected 1", hreadyout0); end
    tests++; if (hresp0 !== 2'b00) begin fails++; $display("FAIL b2b_rd_resp: got %b expected 00", hresp0); end
    tests++; if (hrdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_rd_data: got %h expected deadbeef", hrdata0); end
    @(posedge hclk); #1;
    tests++; if (hrdata0 !== 32'h0) begin fails++; $display("FAIL b2b_idle_data: got %h expected 00000000", hrdata0); end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic [1:0] rsp, rl; int lows;
    xfer(1'b0, 1'b1, 32'h20, 3'b010, 32'h00000000, rd, rsp, rl, lows);
    xfer(1'b0, 1'b1, 32'h21, 3'b000, 32'h0000AA00, rd, rsp, rl, lows);
    tests++; if (lows !== 0) begin fails++; $display("FAIL byte_wr_waits: got %0d expected 0", lows); end
    xfer(1'b0, 1'b1, 32'h22, 3'b001, 32'h12340000, rd, rsp, rl, lows);
    xfer(1'b0, 1'b0, 32'h20, 3'b010, 32'h0, rd, rsp, rl, lows);
    tests++; if (rd !== 32'h1234AA00) begin fails++; $display("FAIL lanes_rd_data: got %h expected 1234aa00", rd); end
    tests++; if (rsp !== 2'b00) begin fails++; $display("FAIL lanes_rd_resp: got %b expected 00", rsp); end
    xfer(1'b0, 1'b1, 32'h20, 3'b000, 32'hFFFFFF5C, rd, rsp, rl, lows);
    xfer(1'b0, 1'b0, 32'h20, 3'b010, 32'h0, rd, rsp, rl, lows);
    tests++; if (rd !== 32'h1234AA5C) begin fails++; $display("FAIL lane0_rd_data: got %h expected 1234aa5c", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic [1:0] rsp, rl; int lows;
    xfer(1'b1, 1'b1, 32'h04, 3'b010, 32'h0BADF00D, rd, rsp, rl, lows);
    tests++; if (lows !== 3) begin fails++; $display("FAIL ws_wr_waits: got %0d expected 3", lows); end
    xfer(1'b1, 1'b0, 32'h04, 3'b010, 32'h0, rd, rsp, rl, lows);
    tests++; if (lows !== 3) begin fails++; $display("FAIL ws_rd_waits: got %0d expected 3", lows); end
    tests++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL ws_rd_data: got %h expected 0badf00d", rd); end
    tests++; if (rsp !== 2'b00) begin fails++; $display("FAIL ws_rd_resp: got %b expected 00", rsp); end
  endtask

  task automatic test_error_path();
    logic [31:0] rd; logic [1:0] rsp, rl; int lows;
    xfer(1'b0, 1'b1, 32'h000, 3'b010, 32'hA5A5A5A5, rd, rsp, rl, lows);
    xfer(1'b0, 1'b1, 32'h400, 3'b010, 32'h11111111, rd, rsp, rl, lows);
`ifdef AHB_SLAVE_MEM_ERR_EN
    tests++; if (lows !== 1) begin fails++; $display("FAIL err_low_cycles: got %0d expected 1", lows); end
    tests++; if (rl !== 2'b01) begin fails++; $display("FAIL err1_resp: got %b expected 01", rl); end
    tests++; if (rsp !== 2'b01) begin fails++; $display("FAIL err2_resp: got %b expected 01", rsp); end
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL err_rdata: got %h expected 00000000", rd); end
    xfer(1'b0, 1'b1, 32'h002, 3'b010, 32'h22222222, rd, rsp, rl, lows);
    tests++; if (rsp !== 2'b01) begin fails++; $display("FAIL misalign_resp: got %b expected 01", rsp); end
    xfer(1'b0, 1'b0, 32'h000, 3'b010, 32'h0, rd, rsp, rl, lows);
    tests++; if (rd !== 32'hA5A5A5A5) begin fails++; $display("FAIL err_mem_kept: got %h expected a5a5a5a5", rd); end
    tests++; if (rsp !== 2'b00) begin fails++; $display("FAIL err_after_resp: got %b expected 00", rsp); end
`else
    tests++; if (rsp !== 2'b00) begin fails++; $display("FAIL wrap_wr_resp: got %b expected 00", rsp); end
    tests++; if (lows !== 0) begin fails++; $display("FAIL wrap_wr_waits: got %0d expected 0", lows); end
    xfer(1'b0, 1'b0, 32'h000, 3'b010, 32'h0, rd, rsp, rl, lows);
    tests++; if (rd !== 32'h11111111) begin fails++; $display("FAIL wrap_rd_data: got %h expected 11111111", rd); end
    xfer(1'b0, 1'b1, 32'h003, 3'b010, 32'h33333333, rd, rsp, rl, lows);
    xfer(1'b0, 1'b0, 32'h000, 3'b010, 32'h0, rd, rsp, rl, lows);
    tests++; if (rd !== 32'h33333333) begin fails++; $display("FAIL align_force_data: got %h expected 33333333", rd); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic [1:0] rsp, rl; int lows;
    xfer(1'b1, 1'b1, 32'h08, 3'b010, 32'hCAFEF00D, rd, rsp, rl, lows);
    hsel1 = 1'b1; htrans = 2'b10; haddr = 32'h08; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    hsel1 = 1'b0; htrans = 2'b00; hwdata = 32'h5555AAAA;
    tests++; if (hreadyout1 !== 1'b0) begin fails++; $display("FAIL rstw_in_wait: got %b expected 0", hreadyout1); end
    #2 hresetn = 1'b0;
    #1;
    tests++; if (hreadyout1 !== 1'b1) begin fails++; $display("FAIL rstw_ready: got %b expected 1", hreadyout1); end
    tests++; if (hresp1 !== 2'b00) begin fails++; $display("FAIL rstw_resp: got %b expected 00", hresp1); end
    tests++; if (hrdata1 !== 32'h0) begin fails++; $display("FAIL rstw_rdata: got %h expected 00000000", hrdata1); end
    repeat (4) @(posedge hclk);
    @(negedge hclk); hresetn = 1'b1;
    @(posedge hclk); #1;
    xfer(1'b1, 1'b0, 32'h08, 3'b010, 32'h0, rd, rsp, rl, lows);
    tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL rstw_mem_kept: got %h expected cafef00d", rd); end
    tests++; if (lows !== 3) begin fails++; $display("FAIL rstw_rd_waits: got %0d expected 3", lows); end
  endtask

  initial begin
    hresetn = 1'b0; hsel0 = 1'b0; hsel1 = 1'b0; haddr = 32'h0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; hwdata = 32'h0;
    repeat (3) @(posedge hclk);
    @(negedge hclk); hresetn = 1'b1;
    @(posedge hclk); #1;
    test_reset();
    test_back_to_back();
    test_byte_half();
    test_wait_states();
    test_error_path();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
